// File: rtl/basic_gates_unit.sv
// Registered bitwise logic unit: seven two-input gate results plus one selected result.
// One-cycle latency, one operation per cycle, all outputs driven straight from flops.
module basic_gates_unit #(
    parameter int WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [2:0]           sel,
    output logic                 out_valid,
    output logic [7*WIDTH-1:0]   y,
    output logic [WIDTH-1:0]     f
);

    logic [WIDTH-1:0]   gate_res [7];
    logic [7*WIDTH-1:0] y_next;
    logic [7*WIDTH-1:0] y_reg;
    logic [WIDTH-1:0]   f_next;
    logic [WIDTH-1:0]   f_reg;
    logic               out_valid_reg;

    // Gate order matches the sel encoding and the slice order in y.
    assign gate_res[0] = ~a;
    assign gate_res[1] = a & b;
    assign gate_res[2] = a | b;
    assign gate_res[3] = ~(a & b);
    assign gate_res[4] = ~(a | b);
    assign gate_res[5] = a ^ b;
    assign gate_res[6] = ~(a ^ b);

    generate
        for (genvar gi = 0; gi < 7; gi++) begin : g_pack
            assign y_next[gi*WIDTH +: WIDTH] = gate_res[gi];
        end
    endgenerate

    // Reserved select code 7 yields all zeros on f.
    always_comb begin
        f_next = '0;
        case (sel)
            3'd0:    f_next = gate_res[0];
            3'd1:    f_next = gate_res[1];
            3'd2:    f_next = gate_res[2];
            3'd3:    f_next = gate_res[3];
            3'd4:    f_next = gate_res[4];
            3'd5:    f_next = gate_res[5];
            3'd6:    f_next = gate_res[6];
            default: f_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_reg         <= '0;
            f_reg         <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= in_valid;
            if (in_valid) begin
                y_reg <= y_next;
                f_reg <= f_next;
            end
        end
    end

    assign y         = y_reg;
    assign f         = f_reg;
    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_basic_gates_unit.sv
// Randomized self-checking bench for basic_gates_unit at WIDTH=1 and WIDTH=8.
// Expected values come from per-gate truth tables applied bit by bit.
module tb_basic_gates_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [2:0]  sel;
    logic [0:0]  a1, b1;
    logic [7:0]  a8, b8;
    logic        v1, v8;
    logic [6:0]  y1;
    logic [0:0]  f1;
    logic [55:0] y8;
    logic [7:0]  f8;

    int total = 0;
    int bad   = 0;

    // Truth table per gate, indexed by {a,b}: bit0=00, bit1=01, bit2=10, bit3=11.
    logic [3:0] tt [7] = '{4'b0011, 4'b1000, 4'b1110, 4'b0111, 4'b0001, 4'b0110, 4'b1001};

    logic [6:0]  exp_y1;
    logic [0:0]  exp_f1;
    logic [55:0] exp_y8;
    logic [7:0]  exp_f8;
    logic        exp_v;

    basic_gates_unit #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a1), .b(b1),
        .sel(sel), .out_valid(v1), .y(y1), .f(f1)
    );

    basic_gates_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a8), .b(b8),
        .sel(sel), .out_valid(v8), .y(y8), .f(f8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [55:0] model_y(input logic [7:0] a, input logic [7:0] b, input int w);
        logic [55:0] r;
        logic [3:0]  row;
        r = '0;
        for (int g = 0; g < 7; g++) begin
            row = tt[g];
            for (int i = 0; i < w; i++)
                r[g*w+i] = row[{a[i], b[i]}];
        end
        return r;
    endfunction

    function automatic logic [7:0] model_f(input logic [55:0] r, input logic [2:0] s, input int w);
        logic [7:0] o;
        o = '0;
        if (s != 3'd7)
            for (int i = 0; i < w; i++)
                o[i] = r[s*w+i];
        return o;
    endfunction

    // Advance the model by one rising edge using the inputs currently applied.
    task automatic model_update();
        logic [55:0] r;
        logic [7:0]  fo;
        if (!rst_n) begin
            exp_y1 = '0; exp_f1 = '0; exp_y8 = '0; exp_f8 = '0; exp_v = 1'b0;
        end else begin
            exp_v = in_valid;
            if (in_valid) begin
                r = model_y({7'd0, a1}, {7'd0, b1}, 1);
                exp_y1 = r[6:0];
                fo = model_f(r, sel, 1);
                exp_f1 = fo[0];
                r = model_y(a8, b8, 8);
                exp_y8 = r;
                exp_f8 = model_f(r, sel, 8);
            end
        end
    endtask

    task automatic clk_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; sel = 3'd1;
        a1 = 1'b1; b1 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
        for (int c = 0; c < 4; c++) begin
            model_update();
            clk_step();
            total++;
            if (y1 !== 7'd0 || f1 !== 1'b0 || v1 !== 1'b0) begin
                bad++; $display("FAIL reset_w1 cyc=%0d got y=%b f=%b v=%b want all 0", c, y1, f1, v1);
            end
            total++;
            if (y8 !== 56'd0 || f8 !== 8'd0 || v8 !== 1'b0) begin
                bad++; $display("FAIL reset_w8 cyc=%0d got y=%h f=%h v=%b want all 0", c, y8, f8, v8);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_truth_table();
        logic [6:0] lit [4] = '{7'b1011001, 7'b0101101, 7'b0101100, 7'b1000110};
        logic [6:0] want;
        sel = 3'd0; in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a1 = k[1]; b1 = k[0];
            model_update();
            clk_step();
            want = lit[k];
            $display("txn truth a=%b b=%b y=%b f=%b", a1, b1, y1, f1);
            total++;
            if (y1 !== want || y1 !== exp_y1) begin
                bad++; $display("FAIL truth_y ab=%0d got=%b want=%b", k, y1, want);
            end
            total++;
            if (f1 !== want[0]) begin
                bad++; $display("FAIL truth_f ab=%0d got=%b want=%b", k, f1, want[0]);
            end
            total++;
            if (v1 !== 1'b1) begin
                bad++; $display("FAIL truth_v ab=%0d got=%b want=1", k, v1);
            end
        end
    endtask

    task automatic test_sel_sweep();
        logic [0:0] lit_f [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        a1 = 1'b1; b1 = 1'b0; in_valid = 1'b1;
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            a8 = 8'($urandom); b8 = 8'($urandom);
            model_update();
            clk_step();
            $display("txn sweep sel=%0d f1=%b f8=%h", s, f1, f8);
            total++;
            if (f1 !== lit_f[s] || f1 !== exp_f1) begin
                bad++; $display("FAIL sweep_f1 sel=%0d got=%b want=%b", s, f1, lit_f[s]);
            end
            total++;
            if (f8 !== exp_f8 || y8 !== exp_y8 || v8 !== 1'b1) begin
                bad++; $display("FAIL sweep_w8 sel=%0d got f=%h y=%h v=%b want f=%h y=%h v=1",
                                s, f8, y8, v8, exp_f8, exp_y8);
            end
        end
    endtask

    task automatic test_bitwise8();
        a8 = 8'hF0; b8 = 8'hCC; sel = 3'd5; in_valid = 1'b1;
        model_update();
        clk_step();
        $display("txn bitwise8 y=%h f=%h", y8, f8);
        total++;
        if (y8 !== 56'hC3_3C_03_3F_FC_C0_0F || y8 !== exp_y8) begin
            bad++; $display("FAIL bitwise8_y got=%h want=%h", y8, 56'hC3_3C_03_3F_FC_C0_0F);
        end
        total++;
        if (f8 !== 8'h3C) begin
            bad++; $display("FAIL bitwise8_f got=%h want=3c", f8);
        end
    endtask

    task automatic test_hold();
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            a1 = 1'($urandom); b1 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
            sel = 3'($urandom);
            model_update();
            clk_step();
            total++;
            if (y8 !== exp_y8 || f8 !== exp_f8 || y1 !== exp_y1 || f1 !== exp_f1) begin
                bad++; $display("FAIL hold_data cyc=%0d got y8=%h f8=%h y1=%b f1=%b want y8=%h f8=%h y1=%b f1=%b",
                                c, y8, f8, y1, f1, exp_y8, exp_f8, exp_y1, exp_f1);
            end
            total++;
            if (v1 !== 1'b0 || v8 !== 1'b0) begin
                bad++; $display("FAIL hold_v cyc=%0d got v1=%b v8=%b want 0", c, v1, v8);
            end
        end
    endtask

    task automatic test_async_reset();
        in_valid = 1'b1; sel = 3'd2; a1 = 1'b1; b1 = 1'b0; a8 = 8'hA5; b8 = 8'h3C;
        model_update();
        clk_step();
        total++;
        if (v8 !== 1'b1 || y8 !== exp_y8) begin
            bad++; $display("FAIL arst_pre got v=%b y=%h want v=1 y=%h", v8, y8, exp_y8);
        end
        #2;
        rst_n = 1'b0;
        #1;
        exp_y1 = '0; exp_f1 = '0; exp_y8 = '0; exp_f8 = '0; exp_v = 1'b0;
        total++;
        if (y8 !== 56'd0 || f8 !== 8'd0 || v8 !== 1'b0 || y1 !== 7'd0 || f1 !== 1'b0 || v1 !== 1'b0) begin
            bad++; $display("FAIL arst_immediate got y8=%h f8=%h v8=%b y1=%b want all 0", y8, f8, v8, y1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        a1 = 1'b0; b1 = 1'b1; a8 = 8'h5A; b8 = 8'h0F; sel = 3'd6;
        model_update();
        clk_step();
        total++;
        if (y8 !== exp_y8 || f8 !== exp_f8 || v8 !== 1'b1 || y1 !== exp_y1 || f1 !== exp_f1) begin
            bad++; $display("FAIL arst_post got y8=%h f8=%h v8=%b want y8=%h f8=%h v8=1",
                            y8, f8, v8, exp_y8, exp_f8);
        end
    endtask

    // Back-to-back when force_valid, otherwise random valid with ~75% density.
    task automatic test_stream(input bit force_valid, input int n);
        for (int c = 0; c < n; c++) begin
            in_valid = force_valid ? 1'b1 : ($urandom_range(0, 3) != 0);
            a1 = 1'($urandom); b1 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
            sel = 3'($urandom);
            model_update();
            clk_step();
            $display("txn stream vld=%b sel=%0d a8=%h b8=%h f8=%h v=%b", in_valid, sel, a8, b8, f8, v8);
            total++;
            if (y8 !== exp_y8 || f8 !== exp_f8) begin
                bad++; $display("FAIL stream_w8 cyc=%0d got y=%h f=%h want y=%h f=%h", c, y8, f8, exp_y8, exp_f8);
            end
            total++;
            if (y1 !== exp_y1 || f1 !== exp_f1) begin
                bad++; $display("FAIL stream_w1 cyc=%0d got y=%b f=%b want y=%b f=%b", c, y1, f1, exp_y1, exp_f1);
            end
            total++;
            if (v1 !== exp_v || v8 !== exp_v) begin
                bad++; $display("FAIL stream_v cyc=%0d got v1=%b v8=%b want %b", c, v1, v8, exp_v);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; sel = '0;
        a1 = '0; b1 = '0; a8 = '0; b8 = '0;
        exp_y1 = '0; exp_f1 = '0; exp_y8 = '0; exp_f8 = '0; exp_v = 1'b0;
        test_reset();
        test_truth_table();
        test_sel_sweep();
        test_bitwise8();
        test_hold();
        test_async_reset();
        test_stream(1'b1, 12);
        test_stream(1'b0, 40);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/basic_gates_unit.md
Name: basic_gates_unit

Overview:
- Registered bitwise logic unit. Computes the seven basic two-input gate functions (NOT, AND, OR, NAND, NOR, XOR, XNOR) on operands a and b in parallel.
- Presents all seven results on a packed vector y, plus one gate result chosen by a select code.
- Used as a small datapath leaf wherever fixed logic primitives are needed behind a valid-qualified, one-cycle-latency register stage.

Parameters:
- WIDTH, 1, bit width of each operand and of each gate result; the legal range is 1 to 64.

Ports:
- clk  input  1  rising-edge clock; the block uses this single clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and sel are sampled on a clk rising edge when this is 1.
- a  input  WIDTH  first operand; it is also the sole operand of NOT.
- b  input  WIDTH  second operand.
- sel  input  3  gate select for f: 0 NOT, 1 AND, 2 OR, 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 reserved.
- out_valid  output  1  is 1 for exactly the cycle after each accepted input.
- y  output  7*WIDTH  all gate results. Gate g occupies y[g*WIDTH +: WIDTH], with g in the same order as sel.
- f  output  WIDTH  the gate result chosen by the registered sel.

Behaviour:
- Gate functions are bitwise per bit position i:
  - g0 = ~a
  - g1 = a&b
  - g2 = a|b
  - g3 = ~(a&b)
  - g4 = ~(a|b)
  - g5 = a^b
  - g6 = ~(a^b)
- With WIDTH=1, y[0] is NOT through y[6] is XNOR.
- Reset: when rst_n is 0, y, f and out_valid clear to 0 immediately, without waiting for clk. They stay 0 while rst_n is 0.
- Reset release: the first capture can happen on the first clk rising edge after rst_n rises.
- Capture: on a rising edge with in_valid=1, y is loaded with all seven results of the current a and b. f is loaded with the result selected by the current sel. out_valid is set to 1.
- Latency is one cycle: results are visible after the sampling edge. Throughput is one operation per cycle, and back-to-back valids are all accepted.
- Hold: on a rising edge with in_valid=0, y and f hold their previous values and out_valid goes to 0.
- sel=7 (reserved): f loads all zeros, y is still computed normally, and out_valid still asserts.
- a and b are fully independent per bit. There is no carry and no cross-bit interaction.
- There is no backpressure input. The downstream consumer must take the result in the out_valid cycle or read the held y and f afterwards.
- Reset mid-stream: any result captured before reset is lost. out_valid is 0 on the first edge after release unless in_valid=1 on that edge.
- No combinational path from the inputs to the outputs. All outputs come straight from flops.

Test Plan:
- Reset: hold rst_n=0 and toggle clk with in_valid=1, a=1, b=1 -> y=0, f=0, out_valid=0 throughout. Drop rst_n between clock edges -> outputs clear immediately.
- WIDTH=1 truth table, one vector per cycle with sel=0:
  - a=0, b=0 -> y=7'b1011001
  - a=0, b=1 -> y=7'b0101101
  - a=1, b=0 -> y=7'b0101100
  - a=1, b=1 -> y=7'b1000110
  - f equals y[0] for each vector; out_valid=1 on each following cycle.
- Select sweep: a=1, b=0, sel stepped 0..7 on consecutive valid cycles -> f = 0,0,1,1,0,1,0,0 respectively.
- WIDTH=8 bitwise check: a=8'hF0, b=8'hCC -> slices g0..g6 = 0F, C0, FC, 3F, 03, 3C, C3.
- Hold and valid: after one valid capture, drive in_valid=0 and change a and b -> y and f unchanged, out_valid=0 from the next edge.
- Async reset mid-stream: assert rst_n=0 between edges while out_valid=1 -> all outputs 0 at once. After release, the first valid input yields a correct result one cycle later.
